// File: rtl/ps2_pkg.sv
// ps2_pkg: shared transmit state encodings and PS/2 framing constants
package ps2_pkg;
   typedef logic [3:0] tx_state_t;
   localparam tx_state_t TX_IDLE     = 4'd0;
   localparam tx_state_t TX_LAST_BIT = 4'd8;
   localparam tx_state_t TX_PARITY   = 4'd9;
   localparam tx_state_t TX_STOP     = 4'd10;
   localparam tx_state_t TX_DONE     = 4'd11;
   localparam logic PS2_START_BIT = 1'b0;
   localparam logic PS2_STOP_BIT  = 1'b1;
endpackage

// File: rtl/ps2_tx_chan.sv
// ps2_tx_chan: one PS/2 device-to-host channel with byte FIFO, frame FSM and host-inhibit retransmit
module ps2_tx_chan import ps2_pkg::*; #(
   parameter int FIFO_BITS = 3
) (
   input  logic       clk_sys,
   input  logic       reset_n,
   input  logic       flush,
   input  logic       wr_en,
   input  logic [7:0] wr_data,
   input  logic       tick,
   input  logic       phase_hi,
   input  logic       ps2_clk_in,
   output logic       fifo_full,
   output logic       overflow,
   output logic       busy,
   output logic       ps2_clk_out,
   output logic       ps2_data_out
);
   localparam int DEPTH = 2 ** FIFO_BITS;
   logic [7:0]         mem [DEPTH];
   logic [FIFO_BITS:0] wp, rp;
   logic [1:0]         sync;
   logic [7:0]         sh;
   logic               parity;
   tx_state_t          state;
   logic               inhibit, empty;
   assign inhibit     = ~sync[1];
   assign empty       = wp == rp;
   assign fifo_full   = (wp - rp) == (FIFO_BITS + 1)'(DEPTH);
   assign busy        = state != TX_IDLE;
   assign ps2_clk_out = phase_hi | (state == TX_IDLE);
   always_ff @(posedge clk_sys)
      if (wr_en && !fifo_full && !flush) mem[wp[FIFO_BITS-1:0]] <= wr_data;
   always_ff @(posedge clk_sys or negedge reset_n)
      if (!reset_n) begin
         wp <= '0;
         rp <= '0;
         sync <= 2'b11;
         sh <= '0;
         parity <= 1'b0;
         state <= TX_IDLE;
         ps2_data_out <= 1'b1;
         overflow <= 1'b0;
      end else begin
         sync <= {sync[0], ps2_clk_in};
         if (flush) begin
            wp <= '0;
            rp <= '0;
            state <= TX_IDLE;
            ps2_data_out <= PS2_STOP_BIT;
            overflow <= 1'b0;
         end else begin
            if (wr_en) begin
               if (fifo_full) overflow <= 1'b1;
               else wp <= wp + 1'b1;
            end
            // abort mid-frame without popping so the byte is resent after release
            if (inhibit && state != TX_IDLE && state != TX_DONE) begin
               state <= TX_IDLE;
               ps2_data_out <= 1'b1;
            end else if (tick) begin
               if (state == TX_IDLE) begin
                  if (!empty && !inhibit) begin
                     sh <= mem[rp[FIFO_BITS-1:0]];
                     parity <= 1'b1;
                     ps2_data_out <= PS2_START_BIT;
                     state <= 4'd1;
                  end
               end else if (state <= TX_LAST_BIT) begin
                  ps2_data_out <= sh[0];
                  sh <= sh >> 1;
                  parity <= parity ^ sh[0];
                  state <= state + 4'd1;
               end else if (state == TX_PARITY) begin
                  ps2_data_out <= parity;
                  state <= TX_STOP;
               end else if (state == TX_STOP) begin
                  ps2_data_out <= PS2_STOP_BIT;
                  state <= TX_DONE;
               end else begin
                  state <= TX_IDLE;
                  rp <= rp + 1'b1;
               end
            end
         end
      end
endmodule

// File: rtl/ps2_tx_multi.sv
// ps2_tx_multi: N-channel PS/2 device emulator; shared bit-period divider and write demux
module ps2_tx_multi import ps2_pkg::*; #(
   parameter int CHANNELS  = 2,
   parameter int FIFO_BITS = 3,
   parameter int CLK_DIV   = 2000,
   parameter int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk_sys,
   input  logic                reset_n,
   input  logic                flush,
   input  logic                wr_en,
   input  logic [CH_W-1:0]     wr_chan,
   input  logic [7:0]          wr_data,
   output logic [CHANNELS-1:0] fifo_full,
   output logic [CHANNELS-1:0] overflow,
   output logic [CHANNELS-1:0] busy,
   output logic [CHANNELS-1:0] ps2_clk_out,
   output logic [CHANNELS-1:0] ps2_data_out,
   input  logic [CHANNELS-1:0] ps2_clk_in
);
   localparam int CW = $clog2(CLK_DIV);
   logic [CW-1:0] cnt;
   logic          tick, phase_hi;
   assign tick     = cnt == '0;
   assign phase_hi = cnt < CW'(CLK_DIV / 2);
   always_ff @(posedge clk_sys or negedge reset_n)
      if (!reset_n) cnt <= '0;
      else cnt <= (cnt == CW'(CLK_DIV - 1)) ? '0 : cnt + 1'b1;
   for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
      ps2_tx_chan #(.FIFO_BITS(FIFO_BITS)) u_chan (
         .clk_sys     (clk_sys),
         .reset_n     (reset_n),
         .flush       (flush),
         .wr_en       (wr_en && wr_chan == CH_W'(g)),
         .wr_data     (wr_data),
         .tick        (tick),
         .phase_hi    (phase_hi),
         .ps2_clk_in  (ps2_clk_in[g]),
         .fifo_full   (fifo_full[g]),
         .overflow    (overflow[g]),
         .busy        (busy[g]),
         .ps2_clk_out (ps2_clk_out[g]),
         .ps2_data_out(ps2_data_out[g])
      );
   end
endmodule

// File: tb/tb_ps2_tx_multi.sv
// tb_ps2_tx_multi: directed scenarios with a per-channel frame scoreboard
module tb_ps2_tx_multi;
   logic       clk_sys = 1'b0;
   logic       reset_n = 1'b0;
   logic       flush = 1'b0;
   logic       wr_en = 1'b0;
   logic [0:0] wr_chan = 1'b0;
   logic [7:0] wr_data = 8'h00;
   logic [1:0] fifo_full, overflow, busy, ps2_clk_out, ps2_data_out;
   logic [1:0] ps2_clk_in = 2'b11;
   int errors = 0;
   int checks = 0;
   logic [10:0] exp_q [2][$];
   logic [10:0] rx [2];
   int nbits [2];
   int blen [2];
   logic [1:0] prev_clk = 2'b11;
   logic [1:0] prev_busy = 2'b00;

   ps2_tx_multi #(.CHANNELS(2), .FIFO_BITS(3), .CLK_DIV(8)) dut (
      .clk_sys(clk_sys), .reset_n(reset_n), .flush(flush), .wr_en(wr_en),
      .wr_chan(wr_chan), .wr_data(wr_data), .fifo_full(fifo_full),
      .overflow(overflow), .busy(busy), .ps2_clk_out(ps2_clk_out),
      .ps2_data_out(ps2_data_out), .ps2_clk_in(ps2_clk_in)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [10:0] frame(input logic [7:0] d);
      return {1'b1, ~^d, d, 1'b0};
   endfunction

   // called at a negedge; returns at the following negedge
   task automatic wr(input int ch, input logic [7:0] d, input bit push);
      wr_en = 1'b1;
      wr_chan = ch[0:0];
      wr_data = d;
      if (push) exp_q[ch].push_back(frame(d));
      @(negedge clk_sys);
      wr_en = 1'b0;
   endtask

   task automatic wait_bits(input int ch, input int k);
      int n = 0;
      while (nbits[ch] != k && n < 500) begin
         @(negedge clk_sys);
         n++;
      end
      chk("wait_bits_timeout", n < 500, 1);
   endtask

   task automatic wait_done(input int max);
      int n = 0;
      while ((busy != 2'b00 || exp_q[0].size() != 0 || exp_q[1].size() != 0) && n < max) begin
         @(negedge clk_sys);
         n++;
      end
      chk("drain_timeout", n < max, 1);
   endtask

   always @(negedge clk_sys) begin
      for (int c = 0; c < 2; c++) begin
         if (prev_clk[c] && !ps2_clk_out[c]) begin
            rx[c] = {ps2_data_out[c], rx[c][10:1]};
            nbits[c]++;
         end
         if (busy[c]) blen[c]++;
         if (prev_busy[c] && !busy[c]) begin
            if (nbits[c] == 11) begin
               chk("frame_expected", exp_q[c].size() != 0, 1);
               if (exp_q[c].size() != 0) chk("frame_bits", rx[c], exp_q[c].pop_front());
               chk("busy_len", blen[c], 88);
            end
            nbits[c] = 0;
            blen[c] = 0;
         end
         if (!busy[c]) chk("idle_lines", {ps2_clk_out[c], ps2_data_out[c]}, 2'b11);
      end
      prev_clk = ps2_clk_out;
      prev_busy = busy;
   end

   initial begin
      nbits = '{0, 0};
      blen = '{0, 0};
      repeat (3) @(negedge clk_sys);
      chk("rst_clk", ps2_clk_out, 2'b11);
      chk("rst_data", ps2_data_out, 2'b11);
      chk("rst_busy", busy, 2'b00);
      chk("rst_full", fifo_full, 2'b00);
      chk("rst_ovf", overflow, 2'b00);
      reset_n = 1'b1;
      repeat (2) @(negedge clk_sys);

      wr(0, 8'h1C, 1);
      chk("frame_1c_const", frame(8'h1C), 11'b1_0_00011100_0);
      wait_done(400);
      chk("single_ch1_idle", busy[1], 1'b0);

      wr(1, 8'h00, 1);
      wait_done(400);

      for (int i = 1; i <= 9; i++) begin
         wr(0, i[7:0], i <= 8);
         if (i == 7) chk("full_after_7", fifo_full[0], 1'b0);
         if (i == 8) chk("full_after_8", fifo_full[0], 1'b1);
      end
      chk("ovf_after_9", overflow, 2'b01);
      chk("full_after_9", fifo_full[0], 1'b1);
      wait_done(2000);
      chk("ovf_sticky", overflow, 2'b01);
      chk("full_drained", fifo_full, 2'b00);

      wr(0, 8'hAA, 1);
      wr(0, 8'h55, 1);
      wait_bits(0, 5);
      ps2_clk_in[0] = 1'b0;
      repeat (3) @(posedge clk_sys);
      #1;
      chk("inh_data", ps2_data_out[0], 1'b1);
      chk("inh_clk", ps2_clk_out[0], 1'b1);
      chk("inh_busy", busy[0], 1'b0);
      repeat (40) @(negedge clk_sys);
      chk("inh_deferred", busy[0], 1'b0);
      ps2_clk_in[0] = 1'b1;
      wait_done(800);

      for (int i = 0; i < 4; i++) wr(0, 8'h30 + i[7:0], 1);
      wait_bits(0, 4);
      flush = 1'b1;
      wr(0, 8'hEE, 0);
      flush = 1'b0;
      exp_q[0].delete();
      #1;
      chk("flush_busy", busy, 2'b00);
      chk("flush_ovf", overflow, 2'b00);
      chk("flush_full", fifo_full, 2'b00);
      chk("flush_lines", {ps2_clk_out[0], ps2_data_out[0]}, 2'b11);
      repeat (200) @(negedge clk_sys);
      chk("flush_quiet", busy, 2'b00);

      wr(1, 8'h3C, 1);
      wr(1, 8'h81, 1);
      wait_bits(1, 7);
      #2 reset_n = 1'b0;
      #1;
      chk("arst_clk", ps2_clk_out, 2'b11);
      chk("arst_data", ps2_data_out, 2'b11);
      chk("arst_busy", busy, 2'b00);
      exp_q[1].delete();
      repeat (4) @(negedge clk_sys);
      reset_n = 1'b1;
      repeat (200) @(negedge clk_sys);
      chk("post_rst_quiet", busy, 2'b00);
      chk("post_rst_full", fifo_full, 2'b00);
      chk("queues_empty", exp_q[0].size() + exp_q[1].size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/ps2_tx_multi.md
Name: ps2_tx_multi

Overview:
- Parametrised successor of the per-port PS/2 keyboard/mouse emulators used inside the IO-controller interface.
- Holds N independent PS/2 device-to-host channels, each with its own byte FIFO of parametrised depth.
- Everything runs on one system clock. The PS/2 clock is derived internally by a divider instead of arriving as a separate core clock.
- Adds three behaviours the older ports lack: host-inhibit detection with retransmit, overflow flags, and flush.

Parameters:
- CHANNELS, 2, number of PS/2 ports (1..8); keyboard = 0, mouse = 1 by convention.
- FIFO_BITS, 3, log2 of per-channel FIFO depth (depth = 2**FIFO_BITS).
- CLK_DIV, 2000, clk_sys cycles per PS/2 bit period; must be even and >= 4.
- CH_W, max(1,$clog2(CHANNELS)), width of the channel select.

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous; empty all FIFOs, abort all frames, clear overflow
- wr_en  in  1  one-cycle write strobe from the SPI command decoder
- wr_chan  in  CH_W  target channel for wr_data
- wr_data  in  8  byte to queue
- fifo_full  out  CHANNELS  per-channel FIFO full
- overflow  out  CHANNELS  sticky; a write was dropped
- busy  out  CHANNELS  frame in progress
- ps2_clk_out  out  CHANNELS  PS/2 clock to core (idle high)
- ps2_data_out  out  CHANNELS  PS/2 data to core (idle high)
- ps2_clk_in  in  CHANNELS  host clock line (low = host inhibit), asynchronous

Behaviour:

Reset (reset_n low, asynchronous):
- FIFOs empty; all pointers and the divider are 0.
- tx_state = 0 on every channel.
- ps2_clk_out = 1, ps2_data_out = 1; overflow, busy and fifo_full = 0.

Divider:
- Counter 0..CLK_DIV-1, shared by all channels.
- phase_hi = (cnt < CLK_DIV/2).
- rise_tick = (cnt == 0). This is the only instant data or state changes.

Clock output:
- ps2_clk_out[c] = phase_hi OR (tx_state[c] == 0).
- The clock is therefore gated high while idle.

FIFO:
- Write when wr_en and wr_chan < CHANNELS; a wr_chan outside that range is ignored.
- Write to a full FIFO: byte dropped, pointers unchanged, overflow[c] set. It stays set until flush or reset.
- Simultaneous write and pop on the same channel in the same cycle: both take effect and the count is unchanged.
- fifo_full = (count == 2**FIFO_BITS). Pointers carry one extra bit to distinguish full from empty.

Transmit FSM (per channel, advances only on rise_tick):
- State 0 (idle): if FIFO not empty and the inhibit flag is clear, load the head byte (no pop yet), parity = 1, data = 0 (start bit), state = 1.
- States 1..8: data = shift_reg[0], shift right, toggle parity if the bit is 1. This gives odd parity.
- State 9: data = parity.
- State 10: data = 1 (stop bit).
- State 11: state = 0 and pop the FIFO.
- One frame is 11 bit periods, i.e. 11 falling clock edges. A new frame may start on the rise_tick right after return to 0.
- busy = (tx_state != 0).

Host inhibit:
- ps2_clk_in is passed through a 2-FF synchroniser. The inhibit flag is the synchronised value being low.
- Inhibit while idle: the frame start is deferred.
- Inhibit seen in states 1..10 (checked every cycle, not only on ticks): state = 0 immediately, data = 1, no pop. The same byte is retransmitted after release.
- Inhibit in state 11: ignored; the frame completes.

Flush:
- Highest priority over wr_en and the FSM in the same cycle.
- Pointers cleared, state 0, data 1, overflow cleared.
- The divider keeps running.

Decomposition:
- Package ps2_pkg holds:
  - state localparams: TX_IDLE = 0, TX_PARITY = 9, TX_STOP = 10, TX_DONE = 11;
  - PS2_START_BIT = 0, PS2_STOP_BIT = 1.
- Sub-module ps2_tx_chan contains one FIFO plus the FSM, the synchroniser and the overflow flag. It is instantiated CHANNELS times via generate.
- The top level holds the divider and the write demux.

Test Plan (CLK_DIV = 8, FIFO_BITS = 3, CHANNELS = 2):
- Single byte: write 0x1C to ch0. ch0 data sampled on ps2_clk_out falling edges is 0,0,0,1,1,1,0,0,0,0,1 (start, LSB-first data, parity 0, stop). busy stays high for 88 cycles. ch1 stays 1/1.
- Parity case: write 0x00 to ch1. Parity bit is 1. ps2_clk_out[0] never toggles.
- Overflow: write 9 bytes 0x01..0x09 to ch0 before the first frame pops. fifo_full goes high after the 8th write and overflow[0] is set. Bytes 0x01..0x08 are transmitted; 0x09 is never sent.
- Inhibit mid-frame: pull ps2_clk_in[0] low during state 5 of byte 0xAA. Data goes to 1 and clock goes high within 3 cycles. After release, the full 0xAA frame is resent, then the next byte.
- Flush: issue flush while 3 bytes are queued and a frame is in state 4, with wr_en on the same cycle. Result: FIFO empty, byte dropped, overflow = 0, lines = 1/1.
- Reset: assert reset_n low during state 7. Outputs go to 1/1 asynchronously; after release nothing is transmitted.
